// File: rtl/sfifo_pkt_desc_pf.sv
// Synchronous descriptor FIFO with a first-word-fall-through output register,
// threshold status and sticky overflow/underflow reporting.
module sfifo_pkt_desc_pf #(
  parameter int WIDTH        = 64,
  parameter int DEPTH_NBITS  = 3,
  parameter int DEPTH        = 2**DEPTH_NBITS,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr,
  input  logic                   rd,
  input  logic                   flush,
  input  logic                   err_clr,
  input  logic [DEPTH_NBITS:0]   afull_th,
  input  logic [DEPTH_NBITS:0]   aempty_th,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   fullm1,
  output logic                   afull,
  output logic                   aempty,
  output logic [DEPTH_NBITS:0]   count,
  output logic [DEPTH_NBITS:0]   ncount,
  output logic                   ovf,
  output logic                   udf,
  output logic [15:0]            drop_cnt
);

  localparam int CW = DEPTH_NBITS + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [DEPTH_NBITS-1:0] PTR_LAST = DEPTH_NBITS'(DEPTH - 2);

  // Handshake: wr/rd are per-cycle requests. A write is taken when
  // wr & (~full | rd) & ~flush; a pop when rd & ~empty & ~flush. ~empty is
  // the valid for dout, and a pop consumes the descriptor currently on dout.
  logic [WIDTH-1:0]       ram [0:DEPTH-2];
  logic [DEPTH_NBITS-1:0] wr_ptr;
  logic [DEPTH_NBITS-1:0] rd_ptr;

  logic wr_acc, rd_acc, wr_blocked, udf_evt;
  logic ovf_evt, drop_evt;
  logic load_din, ram_wr, ram_rd;

  function automatic logic [DEPTH_NBITS-1:0] ptr_inc(input logic [DEPTH_NBITS-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign fullm1 = (count == DEPTH_M1);
  assign afull  = (count >= afull_th);
  assign aempty = (count <= aempty_th);

  assign wr_acc     = wr & (~full | rd) & ~flush;
  assign rd_acc     = rd & ~empty & ~flush;
  assign wr_blocked = wr & full & ~rd & ~flush;
  assign udf_evt    = rd & empty & ~flush;
  assign ovf_evt    = wr_blocked & ~DROP_ON_FULL;
  assign drop_evt   = wr_blocked & DROP_ON_FULL;

  // din bypasses the RAM whenever the output register is (or is becoming) free.
  assign load_din = wr_acc & (empty | (rd_acc & (count == ONE_C)));
  assign ram_wr   = wr_acc & ~load_din;
  assign ram_rd   = rd_acc & (count != ONE_C);

  always_comb begin
    ncount = count;
    if (flush)                ncount = '0;
    else if (wr_acc & ~rd_acc) ncount = count + ONE_C;
    else if (rd_acc & ~wr_acc) ncount = count - ONE_C;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      count <= ncount;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
        if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
      end
      if (load_din)    dout <= din;
      else if (ram_rd) dout <= ram[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram[wr_ptr] <= din;
  end

  // A fresh error in the same cycle as err_clr takes precedence over the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf      <= 1'b0;
      udf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (ovf_evt)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (udf_evt)      udf <= 1'b1;
      else if (err_clr) udf <= 1'b0;
      if (drop_evt) begin
        if (err_clr)                    drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
      end else if (err_clr) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sfifo_pkt_desc_pf.sv
// Self-checking bench for sfifo_pkt_desc_pf: two instances (error and drop
// overflow modes) driven in lockstep against a queue-based reference model.
module tb_sfifo_pkt_desc_pf;

  localparam int W  = 64;
  localparam int NB = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [W-1:0]  din;
  logic          wr, rd, flush, err_clr;
  logic [NB:0]   afull_th, aempty_th;

  logic [W-1:0]  dout, d_dout;
  logic          empty, full, fullm1, afull, aempty, ovf, udf;
  logic          d_empty, d_full, d_fullm1, d_afull, d_aempty, d_ovf, d_udf;
  logic [NB:0]   count, ncount, d_count, d_ncount;
  logic [15:0]   drop_cnt, d_drop_cnt;

  sfifo_pkt_desc_pf #(.WIDTH(W), .DEPTH_NBITS(NB), .DROP_ON_FULL(1'b0)) dut (
    .clk(clk), .rstn(rstn), .din(din), .wr(wr), .rd(rd), .flush(flush),
    .err_clr(err_clr), .afull_th(afull_th), .aempty_th(aempty_th),
    .dout(dout), .empty(empty), .full(full), .fullm1(fullm1), .afull(afull),
    .aempty(aempty), .count(count), .ncount(ncount), .ovf(ovf), .udf(udf),
    .drop_cnt(drop_cnt)
  );

  sfifo_pkt_desc_pf #(.WIDTH(W), .DEPTH_NBITS(NB), .DROP_ON_FULL(1'b1)) dut_d (
    .clk(clk), .rstn(rstn), .din(din), .wr(wr), .rd(rd), .flush(flush),
    .err_clr(err_clr), .afull_th(afull_th), .aempty_th(aempty_th),
    .dout(d_dout), .empty(d_empty), .full(d_full), .fullm1(d_fullm1), .afull(d_afull),
    .aempty(d_aempty), .count(d_count), .ncount(d_ncount), .ovf(d_ovf), .udf(d_udf),
    .drop_cnt(d_drop_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_dout;
  bit           m_ovf, m_udf;
  int           m_drop;
  bit           p_wa, p_ra, p_ovf, p_udf, p_flush, p_clr;
  logic [W-1:0] p_din;

  task automatic model_clear();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0; din = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit w, input bit r, input bit f, input bit e, input logic [W-1:0] d);
    int  n = exp_q.size();
    bit  is_full  = (n == D);
    bit  is_empty = (n == 0);
    wr = w; rd = r; flush = f; err_clr = e; din = d;
    p_wa    = w && (!is_full || r) && !f;
    p_ra    = r && !is_empty && !f;
    p_ovf   = w && is_full && !r && !f;
    p_udf   = r && is_empty && !f;
    p_flush = f;
    p_clr   = e;
    p_din   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    if (p_flush) exp_q.delete();
    else begin
      if (p_ra) void'(exp_q.pop_front());
      if (p_wa) exp_q.push_back(p_din);
    end
    if (exp_q.size() > 0) m_dout = exp_q[0];
    m_ovf  = p_ovf ? 1'b1 : (p_clr ? 1'b0 : m_ovf);
    m_udf  = p_udf ? 1'b1 : (p_clr ? 1'b0 : m_udf);
    m_drop = p_ovf ? (p_clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1)) : (p_clr ? 0 : m_drop);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic step(input bit w, input bit r, input bit f, input bit e, input logic [W-1:0] d);
    drive(w, r, f, e, d);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    afull_th = 4'd6; aempty_th = 4'd1;
    do_reset();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({empty, full, fullm1, aempty, afull} !== 5'b10010) begin
      failures++; $display("FAIL reset_flags got=%b exp=10010", {empty, full, fullm1, aempty, afull}); end
    checks++; if ({ovf, udf, d_ovf, d_udf} !== 4'b0000) begin
      failures++; $display("FAIL reset_err got=%b exp=0000", {ovf, udf, d_ovf, d_udf}); end
    checks++; if (d_drop_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_drop got=%0d/%0d exp=0", drop_cnt, d_drop_cnt); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    afull_th = 4'd0; #1;
    checks++; if (afull !== 1'b1) begin failures++; $display("FAIL reset_afull_th0 got=%b exp=1", afull); end
    afull_th = 4'd6; #1;
  endtask

  task automatic test_fill_drain();
    logic [3:0]   exp_flags;
    logic [W-1:0] e;
    checks++; if (aempty !== 1'b1 || afull !== 1'b0) begin
      failures++; $display("FAIL thr_cnt0 got=%b%b exp=10", aempty, afull); end
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0, 64'hA000_0000_0000_0000 | 64'(i));
      exp_flags = {i == 8, i == 7, i >= 6, i <= 1};
      checks++; if (count !== 4'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
      checks++; if ({full, fullm1, afull, aempty} !== exp_flags) begin
        failures++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {full, fullm1, afull, aempty}, exp_flags); end
      checks++; if (dout !== 64'hA000_0000_0000_0001) begin
        failures++; $display("FAIL fill_head got=%h exp=%h", dout, 64'hA000_0000_0000_0001); end
    end
    for (int i = 1; i <= 8; i++) begin
      e = exp_q[0];
      checks++; if (dout !== e || dout !== (64'hA000_0000_0000_0000 | 64'(i))) begin
        failures++; $display("FAIL drain_order i=%0d got=%h exp=%h", i, dout, e); end
      step(0, 1, 0, 0, '0);
    end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin
      failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    checks++; if (dout !== 64'hA000_0000_0000_0008) begin
      failures++; $display("FAIL drain_hold got=%h exp=%h", dout, 64'hA000_0000_0000_0008); end
  endtask

  task automatic test_wr_rd_empty();
    logic [W-1:0] d1, d2;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    step(1, 1, 0, 0, d1);
    checks++; if (udf !== 1'b1 || d_udf !== 1'b1) begin failures++; $display("FAIL wrrd_empty_udf got=%b exp=1", udf); end
    checks++; if (dout !== d1 || count !== 4'd1) begin
      failures++; $display("FAIL wrrd_empty_dout got=%h/%0d exp=%h/1", dout, count, d1); end
    step(1, 1, 0, 0, d2);
    checks++; if (dout !== d2 || count !== 4'd1) begin
      failures++; $display("FAIL wrrd_one got=%h/%0d exp=%h/1", dout, count, d2); end
    step(0, 0, 0, 1, '0);
    checks++; if (udf !== 1'b0) begin failures++; $display("FAIL udf_clr got=%b exp=0", udf); end
    step(0, 1, 0, 0, '0);
    checks++; if (empty !== 1'b1 || dout !== d2) begin
      failures++; $display("FAIL last_pop got=%b/%h exp=1/%h", empty, dout, d2); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 64'hB000_0000_0000_0000 | 64'(i));
    step(1, 0, 0, 0, 64'hDEAD);
    checks++; if (ovf !== 1'b1 || d_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_set got=%b/%b exp=1/0", ovf, d_ovf); end
    checks++; if (count !== 4'd8 || d_drop_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      failures++; $display("FAIL ovf_count got=%0d drop=%0d/%0d exp=8 drop=0/1", count, drop_cnt, d_drop_cnt); end
    step(1, 0, 0, 0, 64'hDEAD);
    step(1, 0, 0, 0, 64'hDEAD);
    checks++; if (d_drop_cnt !== 16'd3 || d_ovf !== 1'b0) begin
      failures++; $display("FAIL drop_three got=%0d/%b exp=3/0", d_drop_cnt, d_ovf); end
    step(1, 0, 0, 1, 64'hDEAD);
    checks++; if (d_drop_cnt !== 16'd1 || ovf !== 1'b1) begin
      failures++; $display("FAIL clr_and_drop got=%0d/%b exp=1/1", d_drop_cnt, ovf); end
    step(0, 0, 0, 1, '0);
    checks++; if (ovf !== 1'b0 || d_drop_cnt !== 16'd0) begin
      failures++; $display("FAIL err_clr got=%b/%0d exp=0/0", ovf, d_drop_cnt); end
    step(1, 1, 0, 0, 64'hC000_0000_0000_0009);
    checks++; if (count !== 4'd8 || ovf !== 1'b0 || dout !== 64'hB000_0000_0000_0002) begin
      failures++; $display("FAIL full_wrrd got=%0d/%b/%h exp=8/0/%h", count, ovf, dout, 64'hB000_0000_0000_0002); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q[0];
      checks++; if (dout !== e) begin failures++; $display("FAIL ovf_contents i=%0d got=%h exp=%h", i, dout, e); end
      step(0, 1, 0, 0, '0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 64'hD000_0000_0000_0000 | 64'(i));
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", count); end
    drive(1, 0, 1, 0, 64'hEEEE);
    #1;
    checks++; if (ncount !== 4'd0 || d_ncount !== 4'd0) begin
      failures++; $display("FAIL flush_ncount got=%0d exp=0", ncount); end
    tick();
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL flush_state got=%0d/%b exp=0/1", count, empty); end
    checks++; if (dout !== 64'hD000_0000_0000_0001) begin
      failures++; $display("FAIL flush_hold got=%h exp=%h", dout, 64'hD000_0000_0000_0001); end
    step(1, 0, 0, 0, 64'hF00D);
    checks++; if (dout !== 64'hF00D || count !== 4'd1) begin
      failures++; $display("FAIL post_flush_wr got=%h/%0d exp=f00d/1", dout, count); end
    step(0, 1, 0, 0, '0);
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 64'h1234_0000 | 64'(i));
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || dout !== '0) begin
      failures++; $display("FAIL async_reset got=%0d/%b/%h exp=0/1/0", count, empty, dout); end
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    step(1, 0, 0, 0, 64'h5A5A);
    checks++; if (dout !== 64'h5A5A || count !== 4'd1) begin
      failures++; $display("FAIL reset_first_wr got=%h/%0d exp=5a5a/1", dout, count); end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [8:0]   exp_d;
    int           n;
    bit           w, r;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, {$urandom, $urandom});
    for (int c = 0; c < 48; c++) begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        checks++; if (dout !== e || d_dout !== e) begin
          failures++; $display("FAIL rand_dout c=%0d got=%h exp=%h", c, dout, e); end
      end
      w = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 99) < 50);
      step(w, r, 0, 0, {$urandom, $urandom});
      n = exp_q.size();
      checks++; if (count !== 4'(n) || d_count !== 4'(n)) begin
        failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, n); end
      exp_d = {n == 0, n == D, n == D - 1, n >= 6, n <= 1, m_udf, 3'b000};
      checks++; if ({d_empty, d_full, d_fullm1, d_afull, d_aempty, d_udf, d_ovf, ovf ^ m_ovf, 1'b0} !== exp_d) begin
        failures++; $display("FAIL rand_flags c=%0d got=%b exp=%b", c, {d_empty, d_full, d_fullm1, d_afull, d_aempty, d_udf, d_ovf, ovf ^ m_ovf, 1'b0}, exp_d); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q[0];
      checks++; if (dout !== e) begin failures++; $display("FAIL rand_drain got=%h exp=%h", dout, e); end
      step(0, 1, 0, 0, '0);
    end
    checks++; if (empty !== 1'b1 || d_ncount !== 4'd0) begin
      failures++; $display("FAIL rand_end got=%b/%0d exp=1/0", empty, d_ncount); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_wr_rd_empty();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
